// File: rtl/mult_seq_ctrl.sv
// Radix-2 shift-add multiply sequencer for the MIPS EX stage; owns HI/LO and the MFHI/MFLO stall.
// Define MULT_SIGNED_EN to honour op_signed (MULT); otherwise every op is treated as MULTU.
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic [WIDTH-1:0]   opa_mag;
  logic [WIDTH-1:0]   opb_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod;

  assign accept = (state_q == ST_IDLE) && start;

  // One iteration: conditional add with carry kept, then {carry,acc,mplr} shifts right by one.
  assign sum      = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prod_raw = {sum, mplr_q[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic neg_q;

  // Magnitude of the most-negative operand is 2**(WIDTH-1), which fits unsigned.
  assign opa_mag = (op_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign opb_mag = (op_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign prod    = neg_q ? -prod_raw : prod_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= op_signed & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
    end
  end
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign opa_mag          = multiplier;
  assign opb_mag          = multiplicand;
  assign prod             = prod_raw;
`endif

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          mplr_d  = opa_mag;
          mcand_d = opb_mag;
        end
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
      end
      ST_RUN: begin
        {acc_d, mplr_d} = prod_raw;
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d      = ST_DONE;
          {hi_d, lo_d} = prod;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);
  assign stall = mf_req & busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized ops against a plain-arithmetic product model.
module tb_mult_seq_ctrl;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;
  localparam int BOUND   = 100;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op_signed;
  logic [W-1:0] multiplier;
  logic [W-1:0] multiplicand;
  logic         mthi_we;
  logic         mtlo_we;
  logic [W-1:0] wdata;
  logic         mf_req;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_signed    (op_signed),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .mthi_we      (mthi_we),
    .mtlo_we      (mtlo_we),
    .wdata        (wdata),
    .mf_req       (mf_req),
    .busy         (busy),
    .done         (done),
    .stall        (stall),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
`ifdef MULT_SIGNED_EN
    if (sgn) return 64'(sa * sb);
`else
    if (sgn && (sa == sb) && 1'b0) return 64'd0;
`endif
    return 64'(ua * ub);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge with the DUT in RUN, cyc = cycles since the start cycle.
  task automatic wait_done(inout int cyc, output int busy_cyc);
    busy_cyc = 0;
    while (!done && cyc < BOUND) begin
      if (busy) busy_cyc++;
      step();
      cyc++;
    end
  endtask

  task automatic run_mul(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                         output int cyc, output int busy_cyc);
    start        = 1'b1;
    op_signed    = sgn;
    multiplier   = a;
    multiplicand = b;
    step();
    start = 1'b0;
    cyc   = 1;
    wait_done(cyc, busy_cyc);
    r_hi = hi;
    r_lo = lo;
    step();
  endtask

  initial begin
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic [63:0]  exp_p;
    logic [W-1:0] prev_hi;
    int           cyc;
    int           busy_cyc;
    int           done_seen;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
`ifdef MULT_SIGNED_EN
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
`else
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1};
`endif
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
    vecs[4] = '{1'b1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    reset        = 1'b1;
    start        = 1'b0;
    op_signed    = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    mthi_we      = 1'b0;
    mtlo_we      = 1'b0;
    wdata        = '0;
    mf_req       = 1'b0;
    repeat (3) step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_mul(vecs[i].sgn, vecs[i].a, vecs[i].b, r_hi, r_lo, cyc, busy_cyc);
      check($sformatf("vec%0d_hi", i), 64'(r_hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d_lo", i), 64'(r_lo), 64'(vecs[i].exp_lo));
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(LATENCY));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_cyc), 64'(W));
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_idle_busy", i), 64'(busy), 64'd0);
    end

    // start + mthi_we + mf_req during RUN: writes dropped, start ignored, stall raised.
    prev_hi      = hi;
    start        = 1'b1;
    op_signed    = 1'b0;
    multiplier   = 32'h0000_0010;
    multiplicand = 32'h0000_0003;
    step();
    start = 1'b0;
    cyc   = 1;
    repeat (4) begin
      step();
      cyc++;
    end
    start        = 1'b1;
    multiplier   = 32'h0000_0007;
    multiplicand = 32'h0000_0009;
    mthi_we      = 1'b1;
    wdata        = 32'h1234_5678;
    mf_req       = 1'b1;
    #1;
    check("run_stall", 64'(stall), 64'd1);
    step();
    cyc++;
    start   = 1'b0;
    mthi_we = 1'b0;
    mf_req  = 1'b0;
    check("run_mthi_dropped", 64'(hi), 64'(prev_hi));
    check("run_still_busy", 64'(busy), 64'd1);
    wait_done(cyc, busy_cyc);
    check("ign_latency", 64'(cyc), 64'(LATENCY));
    check("ign_product", {hi, lo}, 64'h30);
    step();
    repeat (3) step();
    check("start_not_queued", 64'(busy), 64'd0);
    mf_req = 1'b1;
    #1;
    check("idle_stall", 64'(stall), 64'd0);
    mf_req = 1'b0;

    // Asynchronous reset in the middle of RUN.
    start        = 1'b1;
    multiplier   = 32'hFFFF_FFFF;
    multiplicand = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 10) begin
      step();
      cyc++;
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    step();
    reset     = 1'b0;
    done_seen = 0;
    repeat (40) begin
      step();
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_mul(1'b0, 32'd3, 32'd4, r_hi, r_lo, cyc, busy_cyc);
    check("after_abort_product", {r_hi, r_lo}, 64'h0000_0000_0000_000C);

    // MTHI in IDLE, then MTLO issued together with a start.
    mthi_we = 1'b1;
    wdata   = 32'hDEAD_BEEF;
    step();
    mthi_we = 1'b0;
    check("idle_mthi", 64'(hi), 64'hDEAD_BEEF);
    mtlo_we      = 1'b1;
    wdata        = 32'hAAAA_5555;
    start        = 1'b1;
    multiplier   = 32'd2;
    multiplicand = 32'd3;
    step();
    mtlo_we = 1'b0;
    start   = 1'b0;
    cyc     = 1;
    check("mtlo_with_start", 64'(lo), 64'hAAAA_5555);
    check("mtlo_with_start_busy", 64'(busy), 64'd1);
    wait_done(cyc, busy_cyc);
    check("mtlo_then_product", {hi, lo}, 64'h0000_0000_0000_0006);
    check("mtlo_then_latency", 64'(cyc), 64'(LATENCY));
    step();

    // Randomized operations, weighted toward boundary operands.
    for (int n = 0; n < 24; n++) begin
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h0000_0000;
        3: b = 32'h8000_0000;
        default: ;
      endcase
      exp_p = model(sgn, a, b);
      run_mul(sgn, a, b, r_hi, r_lo, cyc, busy_cyc);
      check($sformatf("rand%0d_%0d_%0h_%0h", n, sgn, a, b), {r_hi, r_lo}, exp_p);
      check($sformatf("rand%0d_latency", n), 64'(cyc), 64'(LATENCY));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
